// File: rtl/sound_sequencer.sv
// Tune sequencer: plays fixed eat/die tunes by driving an 8-bit oscillator
// and toggling a square-wave speaker on each completed half-period.
module sound_sequencer #(
    parameter int NOTE_HP    = 64,
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       event_eat,
    input  logic       event_die,
    input  logic       at_max,
    output logic [7:0] freq,
    output logic       playSound,
    output logic       speaker,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_RESTART,
        S_GAP
    } state_t;

    localparam logic [7:0] NOTE_HP_C  = 8'(NOTE_HP);
    localparam logic [7:0] GAP_LAST_C = 8'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic       tune_q, tune_d;
    logic [1:0] note_q, note_d;
    logic [7:0] hp_q, hp_d;
    logic [7:0] gap_q, gap_d;
    logic       speaker_q, speaker_d;
    logic [7:0] freq_q, freq_d;

    logic       start;
    logic       preempt;
    logic       last_note;

    // tune 0 = eat, tune 1 = die
    function automatic logic [7:0] rom(input logic tune, input logic [1:0] idx);
        logic [7:0] v;
        case ({tune, idx})
            3'b000:  v = 8'd60;
            3'b001:  v = 8'd40;
            3'b100:  v = 8'd80;
            3'b101:  v = 8'd100;
            3'b110:  v = 8'd140;
            3'b111:  v = 8'd200;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    always_comb begin
        state_d   = state_q;
        tune_d    = tune_q;
        note_d    = note_q;
        hp_d      = hp_q;
        gap_d     = gap_q;
        speaker_d = speaker_q;
        freq_d    = freq_q;

        start     = (state_q == S_IDLE) && (event_die || event_eat);
        preempt   = (state_q != S_IDLE) && event_die && !tune_q;
        last_note = tune_q ? (note_q == 2'd3) : (note_q == 2'd1);

        if (!en) begin
            state_d   = S_IDLE;
            tune_d    = 1'b0;
            note_d    = '0;
            hp_d      = '0;
            gap_d     = '0;
            speaker_d = 1'b0;
            freq_d    = '0;
        end else if (start || preempt) begin
            // die has priority in IDLE and is the only event that preempts
            state_d   = S_PLAY;
            tune_d    = event_die;
            note_d    = '0;
            hp_d      = '0;
            gap_d     = '0;
            speaker_d = 1'b0;
            freq_d    = rom(event_die, 2'd0);
        end else begin
            case (state_q)
                S_IDLE: ;
                S_PLAY: begin
                    if (at_max) begin
                        speaker_d = ~speaker_q;
                        hp_d      = hp_q + 8'd1;
                        state_d   = S_RESTART;
                    end
                end
                S_RESTART: begin
                    if (hp_q == NOTE_HP_C) begin
                        hp_d      = '0;
                        speaker_d = 1'b0;
                        if (last_note) begin
                            state_d = S_IDLE;
                            tune_d  = 1'b0;
                            note_d  = '0;
                            freq_d  = '0;
                        end else begin
                            note_d  = note_q + 2'd1;
                            gap_d   = '0;
                            state_d = S_GAP;
                        end
                    end else begin
                        state_d = S_PLAY;
                    end
                end
                S_GAP: begin
                    // freq_q keeps the previous note until the gap expires
                    if (gap_q == GAP_LAST_C) begin
                        gap_d   = '0;
                        state_d = S_PLAY;
                        freq_d  = rom(tune_q, note_q);
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tune_q    <= 1'b0;
            note_q    <= '0;
            hp_q      <= '0;
            gap_q     <= '0;
            speaker_q <= 1'b0;
            freq_q    <= '0;
        end else begin
            state_q   <= state_d;
            tune_q    <= tune_d;
            note_q    <= note_d;
            hp_q      <= hp_d;
            gap_q     <= gap_d;
            speaker_q <= speaker_d;
            freq_q    <= freq_d;
        end
    end

    assign freq      = freq_q;
    assign playSound = (state_q == S_PLAY);
    assign speaker   = speaker_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: oscillator-driven tune timing,
// preemption/abort scenarios and a randomized run against a tune-level model.
module tb_sound_sequencer;

    localparam int NHP = 4;
    localparam int GAP = 16;
    localparam int TRMAX = 2400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       event_eat = 1'b0;
    logic       event_die = 1'b0;
    logic       at_max;
    logic [7:0] freq;
    logic       playSound;
    logic       speaker;
    logic       busy;

    logic       use_osc = 1'b1;
    logic       tb_at_max = 1'b0;
    logic [7:0] osc_cnt = '0;
    logic       osc_at_max = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0] tr_freq [0:TRMAX-1];
    logic       tr_ps   [0:TRMAX-1];
    logic       tr_sp   [0:TRMAX-1];
    logic       tr_bz   [0:TRMAX-1];

    always #5 clk = ~clk;

    assign at_max = use_osc ? osc_at_max : tb_at_max;

    // Oscillator: at_max reached freq+1 cycles after playSound rises, cleared when it falls
    always @(posedge clk) begin
        if (!playSound) begin
            osc_cnt    <= '0;
            osc_at_max <= 1'b0;
        end else if (!osc_at_max) begin
            osc_cnt <= osc_cnt + 8'd1;
            if (osc_cnt + 8'd1 == freq) osc_at_max <= 1'b1;
        end
    end

    sound_sequencer #(.NOTE_HP(NHP), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .en(en), .event_eat(event_eat), .event_die(event_die),
        .at_max(at_max), .freq(freq), .playSound(playSound), .speaker(speaker), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic eat, input logic die);
        event_eat = eat;
        event_die = die;
        tick();
        event_eat = 1'b0;
        event_die = 1'b0;
    endtask

    // Record outputs for cycles 1..n after an event pulse
    task automatic capture(input int n);
        for (int c = 1; c <= n; c++) begin
            tr_freq[c] = freq;
            tr_ps[c]   = playSound;
            tr_sp[c]   = speaker;
            tr_bz[c]   = busy;
            tick();
        end
    endtask

    // ---------------- tune-level reference model ----------------
    int m_tune = -1;
    int m_note, m_hp, m_gap, m_phase;
    bit m_spk;

    function automatic int tune_freq(input int t, input int n);
        int eat_t[2] = '{60, 40};
        int die_t[4] = '{80, 100, 140, 200};
        return (t == 1) ? die_t[n] : eat_t[n];
    endfunction

    function automatic int tune_len(input int t);
        return (t == 1) ? 4 : 2;
    endfunction

    task automatic m_start(input int t);
        m_tune = t; m_note = 0; m_hp = 0; m_gap = 0; m_phase = 0; m_spk = 0;
    endtask

    task automatic m_step(input bit e, input bit eat, input bit die, input bit am);
        if (!e) begin
            m_tune = -1; m_spk = 0;
        end else if (m_tune < 0) begin
            if (die) m_start(1);
            else if (eat) m_start(0);
        end else if (die && m_tune == 0) begin
            m_start(1);
        end else if (m_phase == 0) begin
            if (am) begin m_spk = !m_spk; m_hp++; m_phase = 1; end
        end else if (m_phase == 1) begin
            if (m_hp == NHP) begin
                m_hp = 0; m_spk = 0;
                if (m_note == tune_len(m_tune) - 1) m_tune = -1;
                else begin m_note++; m_gap = 0; m_phase = 2; end
            end else m_phase = 0;
        end else begin
            m_gap++;
            if (m_gap == GAP) begin m_gap = 0; m_phase = 0; end
        end
    endtask

    function automatic int note_end(input int start, input int f);
        return start + NHP * (f + 2) - 1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({freq, playSound, speaker, busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: got freq=%0d ps=%b spk=%b busy=%b, want all 0", freq, playSound, speaker, busy);
        end
    endtask

    task automatic test_eat_tune();
        int exp_t[$];
        int got_t[$];
        int s, last1, s2, endc, bad;
        logic prev;
        use_osc = 1'b1;
        pulse(1'b1, 1'b0);
        capture(460);
        s = 1;
        for (int k = 1; k <= NHP; k++) exp_t.push_back(s + k * 62 - 1);
        last1 = note_end(s, 60);
        s2 = last1 + 1 + GAP;
        for (int k = 1; k <= NHP; k++) exp_t.push_back(s2 + k * 42 - 1);
        endc = note_end(s2, 40) + 1;
        n_cmp++;
        if (tr_freq[1] !== 8'd60 || tr_ps[1] !== 1'b1 || tr_bz[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL eat_first: got freq=%0d ps=%b busy=%b, want 60 1 1", tr_freq[1], tr_ps[1], tr_bz[1]);
        end
        prev = 1'b0;
        for (int c = 1; c <= 460; c++) begin
            if (tr_sp[c] !== prev) got_t.push_back(c);
            prev = tr_sp[c];
        end
        n_cmp++;
        if (got_t.size() != exp_t.size()) begin
            n_fail++;
            $display("FAIL eat_toggle_count: got %0d, want %0d", got_t.size(), exp_t.size());
        end else begin
            for (int i = 0; i < exp_t.size(); i++) begin
                n_cmp++;
                if (got_t[i] != exp_t[i]) begin
                    n_fail++;
                    $display("FAIL eat_toggle_%0d: at cycle %0d, want %0d", i, got_t[i], exp_t[i]);
                end
            end
        end
        bad = 0;
        for (int c = last1 + 1; c < s2; c++)
            if (tr_ps[c] !== 1'b0 || tr_sp[c] !== 1'b0 || tr_bz[c] !== 1'b1 || tr_freq[c] !== 8'd60) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL eat_gap: %0d bad gap cycles, want 0", bad);
        end
        n_cmp++;
        if (tr_freq[s2] !== 8'd40 || tr_ps[s2] !== 1'b1) begin
            n_fail++;
            $display("FAIL eat_note2: got freq=%0d ps=%b, want 40 1", tr_freq[s2], tr_ps[s2]);
        end
        n_cmp++;
        if (tr_bz[endc - 1] !== 1'b1 || tr_bz[endc] !== 1'b0) begin
            n_fail++;
            $display("FAIL eat_end: busy %b,%b at %0d, want 1,0", tr_bz[endc - 1], tr_bz[endc], endc);
        end
    endtask

    task automatic test_simultaneous();
        int want[4] = '{80, 100, 140, 200};
        int seq[$];
        int s, endc;
        use_osc = 1'b1;
        pulse(1'b1, 1'b1);
        capture(2300);
        for (int c = 1; c <= 2300; c++)
            if (tr_bz[c] && tr_ps[c] && (seq.size() == 0 || tr_freq[c] != seq[seq.size() - 1]))
                seq.push_back(int'(tr_freq[c]));
        n_cmp++;
        if (seq.size() != 4) begin
            n_fail++;
            $display("FAIL die_note_count: got %0d, want 4", seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (seq[i] != want[i]) begin
                    n_fail++;
                    $display("FAIL die_note_%0d: got %0d, want %0d", i, seq[i], want[i]);
                end
            end
        end
        s = 1;
        endc = 0;
        for (int i = 0; i < 4; i++) begin
            endc = note_end(s, want[i]) + 1;
            s = endc + GAP;
        end
        n_cmp++;
        if (tr_bz[endc - 1] !== 1'b1 || tr_bz[endc] !== 1'b0) begin
            n_fail++;
            $display("FAIL die_end: busy %b,%b at %0d, want 1,0", tr_bz[endc - 1], tr_bz[endc], endc);
        end
    endtask

    task automatic test_preempt();
        int waited;
        use_osc = 1'b1;
        pulse(1'b1, 1'b0);
        waited = 0;
        while (!(freq == 8'd40 && playSound) && waited < 1000) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (waited >= 1000) begin
            n_fail++;
            $display("FAIL preempt_wait: note 1 never reached, want freq 40");
        end
        repeat (50) tick();
        pulse(1'b0, 1'b1);
        n_cmp++;
        if (freq !== 8'd80 || speaker !== 1'b0 || playSound !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL preempt_die: got freq=%0d spk=%b ps=%b busy=%b, want 80 0 1 1", freq, speaker, playSound, busy);
        end
        repeat (30) tick();
        pulse(1'b1, 1'b0);
        n_cmp++;
        if (freq !== 8'd80 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL eat_ignored: got freq=%0d busy=%b, want 80 1", freq, busy);
        end
        pulse(1'b0, 1'b1);
        n_cmp++;
        if (freq !== 8'd80 || busy !== 1'b1 || speaker !== 1'b0 && playSound !== 1'b0) begin
            n_fail++;
            $display("FAIL die_ignored: got freq=%0d busy=%b, want 80 1", freq, busy);
        end
    endtask

    task automatic test_en_abort();
        int bad;
        en = 1'b0;
        tick();
        n_cmp++;
        if ({freq, playSound, speaker, busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL en_abort: got freq=%0d ps=%b spk=%b busy=%b, want all 0", freq, playSound, speaker, busy);
        end
        pulse(1'b1, 1'b0);
        tick();
        n_cmp++;
        if (busy !== 1'b0 || playSound !== 1'b0) begin
            n_fail++;
            $display("FAIL en_event_ignored: got busy=%b ps=%b, want 0 0", busy, playSound);
        end
        en = 1'b1;
        bad = 0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL en_stays_idle: %0d busy cycles, want 0", bad);
        end
    endtask

    task automatic test_hold_at_max();
        int bad;
        use_osc = 1'b0;
        tb_at_max = 1'b1;
        pulse(1'b1, 1'b0);
        capture(40);
        bad = 0;
        for (int c = 1; c <= 2 * NHP; c++)
            if (tr_ps[c] !== logic'(c % 2) || tr_sp[c] !== logic'((c / 2) % 2) || tr_freq[c] !== 8'd60) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_alternation: %0d bad cycles, want 0", bad);
        end
        bad = 0;
        for (int c = 2 * NHP + 1; c <= 2 * NHP + GAP; c++)
            if (tr_ps[c] !== 1'b0 || tr_sp[c] !== 1'b0 || tr_bz[c] !== 1'b1) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold_gap: %0d bad cycles, want 0", bad);
        end
        n_cmp++;
        if (tr_freq[2 * NHP + GAP + 1] !== 8'd40 || tr_ps[2 * NHP + GAP + 1] !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_note2: got freq=%0d ps=%b, want 40 1", tr_freq[2 * NHP + GAP + 1], tr_ps[2 * NHP + GAP + 1]);
        end
        n_cmp++;
        if (tr_bz[4 * NHP + GAP] !== 1'b1 || tr_bz[4 * NHP + GAP + 1] !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_end: busy %b,%b, want 1,0", tr_bz[4 * NHP + GAP], tr_bz[4 * NHP + GAP + 1]);
        end
        tb_at_max = 1'b0;
        use_osc = 1'b1;
    endtask

    task automatic test_reset_mid();
        int bad;
        use_osc = 1'b1;
        pulse(1'b1, 1'b0);
        repeat (10) tick();
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({freq, playSound, speaker, busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_async: got freq=%0d ps=%b spk=%b busy=%b, want all 0", freq, playSound, speaker, busy);
        end
        tick();
        rst = 1'b0;
        bad = 0;
        repeat (10) begin
            tick();
            if (busy !== 1'b0 || playSound !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_no_resume: %0d busy cycles, want 0", bad);
        end
    endtask

    task automatic test_random();
        logic [7:0] ef;
        logic eps, esp, ebz;
        int bad;
        do_reset();
        m_tune = -1;
        m_spk = 0;
        use_osc = 1'b0;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 149) != 0);
            event_eat = ($urandom_range(0, 29) == 0);
            event_die = ($urandom_range(0, 79) == 0);
            tb_at_max = ($urandom_range(0, 3) == 0);
            tick();
            m_step(en, event_eat, event_die, tb_at_max);
            ebz = (m_tune >= 0);
            eps = ebz && (m_phase == 0);
            esp = ebz && m_spk;
            if (!ebz) ef = 8'd0;
            else if (m_phase == 2) ef = 8'(tune_freq(m_tune, m_note - 1));
            else ef = 8'(tune_freq(m_tune, m_note));
            n_cmp++;
            if ({freq, playSound, speaker, busy} !== {ef, eps, esp, ebz}) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle_%0d: got freq=%0d ps=%b spk=%b busy=%b, want %0d %b %b %b",
                             i, freq, playSound, speaker, busy, ef, eps, esp, ebz);
            end
        end
        en = 1'b1;
        event_eat = 1'b0;
        event_die = 1'b0;
        tb_at_max = 1'b0;
        use_osc = 1'b1;
    endtask

    initial begin
        test_reset();
        test_eat_tune();
        repeat (5) tick();
        test_simultaneous();
        repeat (5) tick();
        test_preempt();
        test_en_abort();
        test_hold_at_max();
        repeat (5) tick();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
